// File: rtl/spi_avalon_master.sv
// Bridge request to Avalon-MM master: write acks 2 cycles after request, read acks after readdatavalid + 1.
// Stalls on avm_waitrequest; the bridge holds its request until req_ack. `AVM_TIMEOUT_EN adds a per-transaction abort.
module spi_avalon_master #(
    parameter int          ADDR_SHIFT      = 2,
    parameter int          TIMEOUT_CYCLES  = 1024,
    parameter logic [31:0] TIMEOUT_PATTERN = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_address,
    input  logic [3:0]  req_byte_enable,
    input  logic [31:0] req_writedata,
    output logic        req_ack,
    output logic [31:0] req_readdata,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        err_timeout,
    input  logic        err_clear
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_DATA = 3'd2;
    localparam logic [2:0] S_ACK       = 3'd3;
    localparam logic [2:0] S_RELEASE   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        timeout_hit;

`ifdef AVM_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        abort;
    logic        busy;

    assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT_DATA);
    assign timeout_hit = busy && ((cnt_q + 16'd1) == 16'(TIMEOUT_CYCLES));
    // A completing handshake on the same edge as expiry takes precedence over the abort.
    assign abort = timeout_hit &&
                   (((state_q == S_ISSUE) && avm_waitrequest) ||
                    ((state_q == S_WAIT_DATA) && !avm_readdatavalid));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = 16'd0;
        end else if (busy) begin
            cnt_d = cnt_q + 16'd1;
        end
        err_d = abort | (err_q & ~err_clear);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt_q <= 16'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    logic unused_ok;

    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
    assign unused_ok   = &{1'b0, err_clear, 32'(TIMEOUT_CYCLES)};
`endif

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_write || req_read) begin
                    state_d = S_ISSUE;
                    wr_d    = req_write;
                    addr_d  = req_address << ADDR_SHIFT;
                    be_d    = req_byte_enable;
                    wdata_d = req_writedata;
                end
            end
            S_ISSUE: begin
                if (!avm_waitrequest) begin
                    if (wr_q) begin
                        state_d = S_ACK;
                    end else if (avm_readdatavalid) begin
                        rdata_d = avm_readdata;
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT_DATA;
                    end
                end else if (timeout_hit) begin
                    state_d = S_ACK;
                    if (!wr_q) begin
                        rdata_d = TIMEOUT_PATTERN;
                    end
                end
            end
            S_WAIT_DATA: begin
                if (avm_readdatavalid) begin
                    rdata_d = avm_readdata;
                    state_d = S_ACK;
                end else if (timeout_hit) begin
                    rdata_d = TIMEOUT_PATTERN;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // Wait for the bridge to drop a still-held request so it is not replayed.
                if (!req_read && !req_write) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign avm_read       = (state_q == S_ISSUE) && !wr_q;
    assign avm_write      = (state_q == S_ISSUE) && wr_q;
    assign avm_address    = addr_q;
    assign avm_byteenable = be_q;
    assign avm_writedata  = wdata_q;
    assign req_ack        = (state_q == S_ACK);
    assign req_readdata   = rdata_q;

endmodule

// File: tb/tb_spi_avalon_master.sv
// Directed bench for spi_avalon_master: vector table plus hand sequences for hold, reset and timeout cases.
module tb_spi_avalon_master;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_address = 32'd0;
    logic [3:0]  req_byte_enable = 4'd0;
    logic [31:0] req_writedata = 32'd0;
    logic        req_ack;
    logic [31:0] req_readdata;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest = 1'b1;
    logic [31:0] avm_readdata = 32'd0;
    logic        avm_readdatavalid = 1'b0;
    logic        err_timeout;
    logic        err_clear = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    spi_avalon_master #(
        .ADDR_SHIFT     (2),
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_PATTERN(32'hDEAD_BEEF)
    ) dut (
        .clk              (clk),
        .nreset           (nreset),
        .req_read         (req_read),
        .req_write        (req_write),
        .req_address      (req_address),
        .req_byte_enable  (req_byte_enable),
        .req_writedata    (req_writedata),
        .req_ack          (req_ack),
        .req_readdata     (req_readdata),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_write        (avm_write),
        .avm_byteenable   (avm_byteenable),
        .avm_writedata    (avm_writedata),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .err_timeout      (err_timeout),
        .err_clear        (err_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          waits;
        int          lat;
        logic [31:0] rdat;
        logic [31:0] exp_addr;
        int          exp_strobes;
        int          exp_ack;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Cycle c counts negedges after the request is driven; the slave answers within the same cycle.
    task automatic run_txn(input string nm, input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd, input int waits, input int lat,
                           input logic [31:0] rdat, input logic [31:0] exp_addr, input int exp_strobes,
                           input int exp_ack, input logic [31:0] exp_rdata, input int hold);
        int c = 0;
        int strobes = 0;
        int acc_c = -1;
        int ack_c = -1;
        int bad = 0;
        int unstable = 0;
        int extra = 0;
        logic [31:0] rd_at_ack = 32'd0;
        req_write       = wr;
        req_read        = rd;
        req_address     = addr;
        req_byte_enable = be;
        req_writedata   = wd;
        while (ack_c < 0 && c < 300) begin
            @(negedge clk);
            c++;
            avm_readdatavalid = 1'b0;
            avm_waitrequest   = 1'b1;
            if (req_ack) begin
                ack_c     = c;
                rd_at_ack = req_readdata;
                if (hold == 0) begin
                    req_write = 1'b0;
                    req_read  = 1'b0;
                end
            end
            if (avm_read || avm_write) begin
                strobes++;
                if (avm_write !== wr || avm_read !== (rd && !wr)) bad++;
                if (avm_address !== exp_addr || avm_byteenable !== be || (wr && avm_writedata !== wd))
                    unstable++;
                if (strobes > waits) begin
                    avm_waitrequest = 1'b0;
                    acc_c = c;
                end
            end
            if (acc_c >= 1 && !wr && c == acc_c + lat) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = rdat;
            end
        end
        for (int i = 1; i <= hold + 3; i++) begin
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            avm_waitrequest   = 1'b1;
            if (req_ack || avm_read || avm_write) extra++;
            if (i == hold) begin
                req_write = 1'b0;
                req_read  = 1'b0;
            end
        end
        req_write = 1'b0;
        req_read  = 1'b0;
        check({nm, ".ack_cycle"}, ack_c, exp_ack);
        check({nm, ".strobe_cycles"}, strobes, exp_strobes);
        check({nm, ".readdata"}, rd_at_ack, exp_rdata);
        check({nm, ".strobe_kind"}, bad, 0);
        check({nm, ".fields"}, unstable, 0);
        check({nm, ".extra_events"}, extra, 0);
    endtask

    initial begin
        logic [31:0] last_rdata;

        //           wr    rd    addr          be    wd            w  lat rdat          exp_addr      st ack exp_rdata
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'hA5A5_1234, 0, 0, 32'h0,        32'h0000_0040, 1, 2, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0003, 4'hF, 32'h0,         3, 2, 32'hCAFE_F00D, 32'h0000_000C, 4, 7, 32'hCAFE_F00D};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0100, 4'hC, 32'h0,         0, 0, 32'h1234_5678, 32'h0000_0400, 1, 2, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b0, 32'hC000_0001, 4'h5, 32'h0000_0000, 2, 0, 32'h0,        32'h0000_0004, 3, 4, 32'h1234_5678};
        vecs[4] = '{1'b0, 1'b1, 32'h3FFF_FFFF, 4'h1, 32'h0,         1, 3, 32'h0F0F_0F0F, 32'hFFFF_FFFC, 2, 6, 32'h0F0F_0F0F};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0007, 4'h3, 32'h1111_2222, 0, 0, 32'hFFFF_FFFF, 32'h0000_001C, 1, 2, 32'h0F0F_0F0F};

        repeat (3) @(negedge clk);
        check("reset.flags", {28'd0, req_ack, avm_read, avm_write, err_timeout}, 32'd0);
        check("reset.address", avm_address, 32'd0);
        check("reset.readdata", req_readdata, 32'd0);
        check("reset.be_wdata", {avm_byteenable, avm_writedata[27:0]}, 32'd0);
        nreset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_txn($sformatf("vec%0d", v), vecs[v].wr, vecs[v].rd, vecs[v].addr, vecs[v].be, vecs[v].wd,
                    vecs[v].waits, vecs[v].lat, vecs[v].rdat, vecs[v].exp_addr, vecs[v].exp_strobes,
                    vecs[v].exp_ack, vecs[v].exp_rdata, 0);
        end

        run_txn("held", 1'b1, 1'b0, 32'h20, 4'hF, 32'h0BAD_F00D, 0, 0, 32'h0, 32'h80, 1, 2, 32'h0F0F_0F0F, 20);
        run_txn("after_held", 1'b0, 1'b1, 32'h21, 4'hF, 32'h0, 0, 1, 32'h600D_CAFE, 32'h84, 1, 3,
                32'h600D_CAFE, 0);

`ifdef AVM_TIMEOUT_EN
        run_txn("timeout", 1'b0, 1'b1, 32'h9, 4'hF, 32'h0, 1000, 1, 32'h0, 32'h24, 8, 9, 32'hDEAD_BEEF, 0);
        check("timeout.err_set", {31'd0, err_timeout}, 32'd1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("timeout.err_cleared", {31'd0, err_timeout}, 32'd0);
        last_rdata = 32'hDEAD_BEEF;
`else
        run_txn("long_wait", 1'b0, 1'b1, 32'h9, 4'hF, 32'h0, 40, 1, 32'h7777_8888, 32'h24, 41, 43,
                32'h7777_8888, 0);
        check("long_wait.err", {31'd0, err_timeout}, 32'd0);
        last_rdata = 32'h7777_8888;
`endif

        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hBAD0_BAD0;
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        check("stale.ack", {31'd0, req_ack}, 32'd0);
        @(negedge clk);
        check("stale.readdata", req_readdata, last_rdata);

        req_read        = 1'b1;
        req_address     = 32'h5;
        req_byte_enable = 4'hF;
        @(negedge clk);
        check("rst_mid.strobe", {31'd0, avm_read}, 32'd1);
        avm_waitrequest = 1'b0;
        @(negedge clk);
        avm_waitrequest = 1'b1;
        check("rst_mid.wait_data", {30'd0, avm_read, req_ack}, 32'd0);
        nreset = 1'b0;
        @(negedge clk);
        check("rst_mid.flags", {28'd0, req_ack, avm_read, avm_write, err_timeout}, 32'd0);
        check("rst_mid.address", avm_address, 32'd0);
        check("rst_mid.readdata", req_readdata, 32'd0);
        nreset = 1'b1;
        run_txn("reissue", 1'b0, 1'b1, 32'h5, 4'hF, 32'h0, 0, 1, 32'h55AA_55AA, 32'h14, 1, 3, 32'h55AA_55AA, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
